sram_axi_bridge_mp: RTL and testbench
=====================================

// Module: sram_axi_bridge_mp
// PURPOSE
//  Parametrised SRAM-like to AXI3 bridge: NUM_PORTS SRAM-like master ports (port 0 = inst, 1 = data, more for cache refill/uncached).
//  Sits between CPU pipeline/caches and the AXI crossbar.
//  Multiple outstanding reads per port; FIFO-tracked outstanding writes.
//  Per-address read-after-write hazard blocking replaces "block all reads while any write is pending".
// PARAMETERS
//  NUM_PORTS   2   number of SRAM-like ports (1..8)
//  MAX_RD      4   max outstanding reads per port (power of 2)
//  WR_DEPTH    4   max outstanding writes (AW accepted, B not yet returned; power of 2)
//  WR_ID       4'hF  AXI ID used for all writes (keeps B responses in order)
// PORTS
//  aclk            in   1        clock
//  aresetn         in   1        asynchronous active-low reset
//  req/wr          in   P, P     per-port request valid / 1=write
//  size            in   2*P      per-port size: 0=1B, 1=2B, 2=4B
//  wstrb           in   4*P      per-port byte strobes
//  addr/wdata      in   32*P     per-port address / write data
//  addr_ok/data_ok out  P, P     per-port request accepted / response done
//  rdata           out  32*P     per-port read data (valid with data_ok of a read)
//  ar*/r*/aw*/w*/b*  AXI3 master: arid/awid/wid 4b, araddr/awaddr 32b, len=0, size 3b, burst=INCR, lock/cache/prot=0, wlast=1
// BEHAVIOUR
//  Reset: arvalid, awvalid, wvalid, addr_ok, data_ok = 0; all counters and FIFO pointers 0; rready = bready = 1 always.
//  Read path: one AR output register.
//  - Port i eligible when req&!wr, rd_cnt[i]<MAX_RD, and no RAW hit.
//  - Winner granted only when slot free (!arvalid | arready); addr_ok[i]=1 that cycle.
//  - arvalid=1, arid=i, araddr, arsize loaded next cycle (1-cycle latency).
//  - rd_cnt[i] ++ on grant, -- on rvalid&&rid==i; both same cycle: unchanged.
//  - data_ok[i]=rvalid&&rid==i, combinational; rdata[i]=rdata, else 0.
//  - rid outside 0..P-1 is dropped.
//  RAW hit: addr[31:2] equals a valid write-FIFO entry, the AW register, or the write winner this cycle. Read held (addr_ok=0) until cleared.
//  Write path: independent arbiter over req&wr ports.
//  - Grant when AW and W registers both empty (or draining this cycle) and FIFO not full.
//  - Grant -> addr_ok[i]; awvalid & wvalid set next cycle; awid=wid=WR_ID.
//  - AW and W clear independently on their own handshakes; the next write waits until both clear.
//  - Grant pushes {port, addr[31:2]} into write FIFO (depth WR_DEPTH).
//  - bvalid pops head; data_ok[head.port]=1 that cycle. Push+pop same cycle: count unchanged.
//  - Full: write addr_ok=0. B with empty FIFO: ignored.
//  Same port: read data_ok and B data_ok in the same cycle -> data_ok[i] high 1 cycle; read data takes rdata. Ports must not rely on mixed-order reads and writes.
//  size>2 never issued; arsize/awsize={1'b0,size}.
//  Reset mid-transfer: all state cleared asynchronously; in-flight AXI responses after reset release are dropped by ID/FIFO checks.
// CONFIGURATION
//  SRAM_AXI_RR_ARB_EN defined: both arbiters round-robin.
//  - Pointer starts after the last granted port; pointer reset 0.
//  Undefined: fixed priority, highest port index wins (data over inst). No pointer state.
// STRUCTURE
//  Shared include/package sram_axi_pkg: size encodings, AXI constant fields (burst INCR, len 0), INST_ID=0, DATA_ID=1, WR_ID default.
//  One sub-module sram_axi_arb (NUM_PORTS, req vector, grant_en -> onehot grant + index).
//  - Instantiated twice (AR, AW); holds the RR pointer under the macro.
// TESTING
//  1 P=2: inst read 0x1c000000, arready=1, rvalid rid=0 after 3 cyc
//    -> addr_ok[0] cyc0, arvalid cyc1, data_ok[0] with rdata.
//  2 Port0 issues 5 reads, no rvalid
//    -> 4 addr_ok, 5th stalls until first rvalid, then accepted.
//  3 Write 0x80000010 (bvalid held off), then read 0x80000012
//    -> read blocked until B; read 0x80000020 proceeds meanwhile.
//  4 5 writes, bvalid withheld -> 4 accepted, 5th held; B pops return data_ok to correct ports in order.
//  5 Both ports read every cycle, arready=1 -> RR: alternating grants 0,1,0,1; fixed: port1 always wins.
//  6 Assert aresetn low with 2 reads in flight, then release; return stale rvalid -> no data_ok, all outputs at reset values.

Source files
------------

// File: rtl/sram_axi_pkg.sv
// sram_axi_pkg: shared encodings for the SRAM-like to AXI3 bridge.
// Holds the SRAM-like size encodings, the fixed AXI3 field values and default IDs.
package sram_axi_pkg;

  typedef enum logic [1:0] {
    SIZE_1B = 2'd0,
    SIZE_2B = 2'd1,
    SIZE_4B = 2'd2
  } sram_size_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [3:0] AXI_LEN_SINGLE  = 4'd0;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE  = 4'd0;
  localparam logic [2:0] AXI_PROT_NONE   = 3'd0;

  localparam logic [3:0] INST_ID       = 4'd0;
  localparam logic [3:0] DATA_ID       = 4'd1;
  localparam logic [3:0] WR_ID_DEFAULT = 4'hF;

  // One outstanding write: owning port and word address (for RAW matching).
  typedef struct packed {
    logic [2:0]  port;
    logic [29:0] waddr;
  } wr_entry_t;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_arb.sv
// sram_axi_arb: request arbiter producing a one-hot grant and winner index.
// SRAM_AXI_RR_ARB_EN defined: round-robin with a pointer after the last granted port.
// Undefined: fixed priority, highest port index wins, no state.
module sram_axi_arb #(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 grant_en,
  output logic [NUM_PORTS-1:0] grant,
  output logic [2:0]           grant_idx,
  output logic                 grant_any
);

`ifdef SRAM_AXI_RR_ARB_EN
  logic [2:0]  ptr;
  int unsigned cand;

  // Round-robin pick: first requester at or after the pointer.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!grant_any && req[cand]) begin
        grant_any = 1'b1;
        grant_idx = 3'(cand);
      end
    end
  end

  // Pointer advances to the port after the one just granted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr <= '0;
    end else if (grant_en && grant_any) begin
      ptr <= (grant_idx == 3'(NUM_PORTS - 1)) ? '0 : grant_idx + 3'd1;
    end
  end
`else
  logic unused_arb;
  assign unused_arb = ^{aclk, aresetn, grant_en};

  // Fixed priority: the highest-index requester wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (req[k]) begin
        grant_any = 1'b1;
        grant_idx = 3'(k);
      end
    end
  end
`endif

  // Expand the winning index to a one-hot grant.
  always_comb begin
    grant = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      grant[k] = grant_any && (grant_idx == 3'(k));
    end
  end

endmodule

// File: rtl/sram_axi_bridge_mp.sv
// sram_axi_bridge_mp: NUM_PORTS SRAM-like master ports to one AXI3 master.
// Multiple outstanding reads per port, FIFO-tracked writes, per-word RAW blocking.
// Arbitration policy selected by SRAM_AXI_RR_ARB_EN (see sram_axi_arb).
module sram_axi_bridge_mp
  import sram_axi_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned MAX_RD    = 4,
  parameter int unsigned WR_DEPTH  = 4,
  parameter logic [3:0]  WR_ID     = WR_ID_DEFAULT
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_PORTS-1:0]   req,
  input  logic [NUM_PORTS-1:0]   wr,
  input  logic [2*NUM_PORTS-1:0] size,
  input  logic [4*NUM_PORTS-1:0] wstrb,
  input  logic [32*NUM_PORTS-1:0] addr,
  input  logic [32*NUM_PORTS-1:0] wdata,
  output logic [NUM_PORTS-1:0]   addr_ok,
  output logic [NUM_PORTS-1:0]   data_ok,
  output logic [32*NUM_PORTS-1:0] rdata,
  output logic [3:0]             arid,
  output logic [31:0]            araddr,
  output logic [3:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic [1:0]             arlock,
  output logic [3:0]             arcache,
  output logic [2:0]             arprot,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [3:0]             rid,
  input  logic [31:0]            axi_rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [3:0]             awid,
  output logic [31:0]            awaddr,
  output logic [3:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic [1:0]             awlock,
  output logic [3:0]             awcache,
  output logic [2:0]             awprot,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [3:0]             wid,
  output logic [31:0]            axi_wdata,
  output logic [3:0]             axi_wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [3:0]             bid,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready
);

  localparam int unsigned RC_W = $clog2(MAX_RD) + 1;
  localparam int unsigned FP_W = $clog2(WR_DEPTH);
  localparam int unsigned FC_W = FP_W + 1;

  logic [NUM_PORTS-1:0] rd_req, wr_req, raw_hit, rd_elig, rd_ok;
  logic [NUM_PORTS-1:0] ar_win, aw_win;
  logic [2:0]           ar_idx, aw_idx;
  logic                 ar_any, aw_any, ar_grant, wr_grant;
  logic [31:0]          ar_sel_addr, aw_sel_addr, aw_sel_data;
  logic [1:0]           ar_sel_size, aw_sel_size;
  logic [3:0]           aw_sel_strb;
  logic [RC_W-1:0]      rd_cnt [NUM_PORTS];
  wr_entry_t            fifo_q [WR_DEPTH];
  logic [WR_DEPTH-1:0]  fifo_vld;
  logic [FP_W-1:0]      fifo_wp, fifo_rp;
  logic [FC_W-1:0]      fifo_cnt;
  logic                 fifo_full, b_pop;
  logic [2:0]           head_port;
  logic                 unused_inputs;

  assign unused_inputs = ^{rresp, rlast, bid, bresp};

  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NORMAL;
  assign arcache = AXI_CACHE_NONE;
  assign arprot  = AXI_PROT_NONE;
  assign rready  = 1'b1;
  assign awid    = WR_ID;
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = AXI_LOCK_NORMAL;
  assign awcache = AXI_CACHE_NONE;
  assign awprot  = AXI_PROT_NONE;
  assign wid     = WR_ID;
  assign wlast   = 1'b1;
  assign bready  = 1'b1;

  // Split requests into read and write candidates.
  always_comb begin
    rd_req = req & ~wr;
    wr_req = req & wr;
  end

  // Route the winning ports' request fields to the AR / AW+W registers.
  always_comb begin
    ar_sel_addr = '0;
    ar_sel_size = '0;
    aw_sel_addr = '0;
    aw_sel_size = '0;
    aw_sel_data = '0;
    aw_sel_strb = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (ar_win[i]) begin
        ar_sel_addr = addr[32*i +: 32];
        ar_sel_size = size[2*i +: 2];
      end
      if (aw_win[i]) begin
        aw_sel_addr = addr[32*i +: 32];
        aw_sel_size = size[2*i +: 2];
        aw_sel_data = wdata[32*i +: 32];
        aw_sel_strb = wstrb[4*i +: 4];
      end
    end
  end

  // A read is held while its word matches any write not yet answered by B.
  always_comb begin
    raw_hit = '0;
    rd_elig = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (awvalid && awaddr[31:2] == addr[32*i+2 +: 30]) raw_hit[i] = 1'b1;
      if (aw_any && aw_sel_addr[31:2] == addr[32*i+2 +: 30]) raw_hit[i] = 1'b1;
      for (int unsigned e = 0; e < WR_DEPTH; e++) begin
        if (fifo_vld[e] && fifo_q[e].waddr == addr[32*i+2 +: 30]) raw_hit[i] = 1'b1;
      end
      rd_elig[i] = rd_req[i] && (rd_cnt[i] != RC_W'(MAX_RD)) && !raw_hit[i];
    end
  end

  sram_axi_arb #(.NUM_PORTS(NUM_PORTS)) u_ar_arb (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req       (rd_elig),
    .grant_en  (ar_grant),
    .grant     (ar_win),
    .grant_idx (ar_idx),
    .grant_any (ar_any)
  );

  sram_axi_arb #(.NUM_PORTS(NUM_PORTS)) u_aw_arb (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req       (wr_req),
    .grant_en  (wr_grant),
    .grant     (aw_win),
    .grant_idx (aw_idx),
    .grant_any (aw_any)
  );

  assign fifo_full = (fifo_cnt == FC_W'(WR_DEPTH));
  assign b_pop     = bvalid && (fifo_cnt != '0);
  assign head_port = fifo_q[fifo_rp].port;
  assign ar_grant  = ar_any && (!arvalid || arready);
  assign wr_grant  = aw_any && (!awvalid || awready) && (!wvalid || wready) && !fifo_full;

  // Per-port handshakes: accept on grant, complete on R (own ID, outstanding) or B pop.
  always_comb begin
    addr_ok = '0;
    data_ok = '0;
    rdata   = '0;
    rd_ok   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      rd_ok[i]   = rvalid && (rid == 4'(i)) && (rd_cnt[i] != '0);
      addr_ok[i] = (ar_grant && ar_win[i]) || (wr_grant && aw_win[i]);
      data_ok[i] = rd_ok[i] || (b_pop && head_port == 3'(i));
      if (rd_ok[i]) rdata[32*i +: 32] = axi_rdata;
    end
  end

  // AR output register: load on grant, clear on handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arvalid <= 1'b0;
      arid    <= '0;
      araddr  <= '0;
      arsize  <= '0;
    end else if (ar_grant) begin
      arvalid <= 1'b1;
      arid    <= {1'b0, ar_idx};
      araddr  <= ar_sel_addr;
      arsize  <= axi_size(ar_sel_size);
    end else if (arready) begin
      arvalid <= 1'b0;
    end
  end

  // AW output register: load on write grant, clear on its own handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awvalid <= 1'b0;
      awaddr  <= '0;
      awsize  <= '0;
    end else if (wr_grant) begin
      awvalid <= 1'b1;
      awaddr  <= aw_sel_addr;
      awsize  <= axi_size(aw_sel_size);
    end else if (awready) begin
      awvalid <= 1'b0;
    end
  end

  // W output register: load on write grant, clear on its own handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wvalid    <= 1'b0;
      axi_wdata <= '0;
      axi_wstrb <= '0;
    end else if (wr_grant) begin
      wvalid    <= 1'b1;
      axi_wdata <= aw_sel_data;
      axi_wstrb <= aw_sel_strb;
    end else if (wready) begin
      wvalid <= 1'b0;
    end
  end

  // Outstanding read count per port; grant and return together cancel.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) rd_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        case ({ar_grant && ar_win[i], rd_ok[i]})
          2'b10:   rd_cnt[i] <= rd_cnt[i] + RC_W'(1);
          2'b01:   rd_cnt[i] <= rd_cnt[i] - RC_W'(1);
          default: rd_cnt[i] <= rd_cnt[i];
        endcase
      end
    end
  end

  // Write FIFO control: push on write grant, pop on B.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fifo_wp  <= '0;
      fifo_rp  <= '0;
      fifo_cnt <= '0;
      fifo_vld <= '0;
    end else begin
      if (wr_grant) begin
        fifo_vld[fifo_wp] <= 1'b1;
        fifo_wp           <= fifo_wp + FP_W'(1);
      end
      if (b_pop) begin
        fifo_vld[fifo_rp] <= 1'b0;
        fifo_rp           <= fifo_rp + FP_W'(1);
      end
      case ({wr_grant, b_pop})
        2'b10:   fifo_cnt <= fifo_cnt + FC_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - FC_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Write FIFO payload; validity is tracked by fifo_vld.
  always_ff @(posedge aclk) begin
    if (wr_grant) begin
      fifo_q[fifo_wp] <= '{port: aw_idx, waddr: aw_sel_addr[31:2]};
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge_mp.sv
// tb_sram_axi_bridge_mp: directed self-checking bench for sram_axi_bridge_mp, NUM_PORTS=2.
// Expectations for arbitration follow SRAM_AXI_RR_ARB_EN as built.
module tb_sram_axi_bridge_mp;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [1:0]  req = '0, wr = '0, addr_ok, data_ok;
  logic [3:0]  size = '0;
  logic [7:0]  wstrb = '0;
  logic [63:0] addr = '0, wdata = '0, rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, axi_wstrb;
  logic [31:0] araddr, awaddr, axi_wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, rready, awvalid, wlast, wvalid, bready;
  logic        arready = 1'b0, rlast = 1'b1, rvalid = 1'b0, awready = 1'b0;
  logic        wready = 1'b0, bvalid = 1'b0;
  logic [3:0]  rid = '0, bid = '0;
  logic [31:0] axi_rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  sram_axi_bridge_mp #(
    .NUM_PORTS(2), .MAX_RD(4), .WR_DEPTH(4), .WR_ID(4'hF)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .axi_rdata(axi_rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic set_port(input int p, input logic r, input logic w, input logic [31:0] a);
    req[p]            = r;
    wr[p]             = w;
    addr[32*p +: 32]  = a;
    size[2*p +: 2]    = 2'd2;
    wstrb[4*p +: 4]   = 4'hF;
    wdata[32*p +: 32] = a ^ 32'h5A5A_5A5A;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    #1;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%b exp=0", arvalid); end
    checks++; if ({awvalid, wvalid} !== 2'b00) begin errors++; $display("FAIL reset_aw_w got=%b exp=00", {awvalid, wvalid}); end
    checks++; if ({addr_ok, data_ok} !== 4'b0000) begin errors++; $display("FAIL reset_ok got=%b exp=0000", {addr_ok, data_ok}); end
    checks++; if ({rready, bready, wlast} !== 3'b111) begin errors++; $display("FAIL reset_ready got=%b exp=111", {rready, bready, wlast}); end
    checks++; if ({arburst, arlen, awid, wid} !== {2'b01, 4'd0, 4'hF, 4'hF}) begin errors++; $display("FAIL const_fields got=%h exp=%h", {arburst, arlen, awid, wid}, {2'b01, 4'd0, 4'hF, 4'hF}); end
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_arb();
    logic [1:0] exp_ok [4];
    int cnt0 = 0, cnt1 = 0;
`ifdef SRAM_AXI_RR_ARB_EN
    exp_ok = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_ok = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      set_port(0, 1'b1, 1'b0, 32'h1000_0000 + 32'(4*k));
      set_port(1, 1'b1, 1'b0, 32'h2000_0000 + 32'(4*k));
      #1;
      checks++; if (addr_ok !== exp_ok[k]) begin errors++; $display("FAIL arb_grant%0d got=%b exp=%b", k, addr_ok, exp_ok[k]); end
      if (exp_ok[k] == 2'b10) cnt1++; else cnt0++;
    end
    @(negedge aclk);
    set_port(0, 1'b0, 1'b0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0);
    #1;
    checks++; if (arid !== ((exp_ok[3] == 2'b10) ? 4'd1 : 4'd0)) begin errors++; $display("FAIL arb_arid got=%0d", arid); end
    for (int n = 0; n < cnt1 + cnt0; n++) begin
      @(negedge aclk);
      rvalid = 1'b1; rid = (n < cnt1) ? 4'd1 : 4'd0; axi_rdata = 32'hA000_0000 + 32'(n);
      #1;
      checks++; if (data_ok !== ((n < cnt1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL arb_drain%0d got=%b", n, data_ok); end
    end
    @(negedge aclk);
    rvalid = 1'b0;
  endtask

  task automatic test_single_read();
    @(negedge aclk);
    set_port(0, 1'b1, 1'b0, 32'h1c00_0000);
    #1;
    checks++; if (addr_ok !== 2'b01) begin errors++; $display("FAIL rd_addr_ok got=%b exp=01", addr_ok); end
    @(negedge aclk);
    set_port(0, 1'b0, 1'b0, 32'h0);
    #1;
    checks++; if ({arvalid, arid, araddr, arsize} !== {1'b1, 4'd0, 32'h1c00_0000, 3'd2}) begin errors++; $display("FAIL rd_ar got=%h exp=%h", {arvalid, arid, araddr, arsize}, {1'b1, 4'd0, 32'h1c00_0000, 3'd2}); end
    @(negedge aclk);
    rvalid = 1'b1; rid = 4'd3; axi_rdata = 32'h1234_5678;
    #1;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rd_ar_clear got=%b exp=0", arvalid); end
    checks++; if (data_ok !== 2'b00) begin errors++; $display("FAIL rd_bad_rid got=%b exp=00", data_ok); end
    @(negedge aclk);
    rid = 4'd0; axi_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (data_ok !== 2'b01) begin errors++; $display("FAIL rd_data_ok got=%b exp=01", data_ok); end
    checks++; if (rdata !== {32'h0, 32'hDEAD_BEEF}) begin errors++; $display("FAIL rd_rdata got=%h exp=%h", rdata, {32'h0, 32'hDEAD_BEEF}); end
    @(negedge aclk);
    rvalid = 1'b0;
    #1;
    checks++; if (data_ok !== 2'b00) begin errors++; $display("FAIL rd_data_ok_drop got=%b exp=00", data_ok); end
  endtask

  task automatic test_max_outstanding();
    logic [1:0] exp_ok [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    for (int k = 0; k < 7; k++) begin
      @(negedge aclk);
      set_port(0, 1'b1, 1'b0, 32'h3000_0000 + 32'(16*k));
      rvalid = (k == 6); rid = 4'd0;
      #1;
      checks++; if (addr_ok !== exp_ok[k]) begin errors++; $display("FAIL maxrd_addr_ok%0d got=%b exp=%b", k, addr_ok, exp_ok[k]); end
    end
    checks++; if (data_ok !== 2'b01) begin errors++; $display("FAIL maxrd_first_ret got=%b exp=01", data_ok); end
    @(negedge aclk);
    rvalid = 1'b0;
    #1;
    checks++; if (addr_ok !== 2'b01) begin errors++; $display("FAIL maxrd_fifth got=%b exp=01", addr_ok); end
    @(negedge aclk);
    set_port(0, 1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 4; n++) begin
      @(negedge aclk);
      rvalid = 1'b1;
      #1;
      checks++; if (data_ok !== 2'b01) begin errors++; $display("FAIL maxrd_drain%0d got=%b exp=01", n, data_ok); end
    end
    @(negedge aclk);
    rvalid = 1'b0;
  endtask

  task automatic test_raw();
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    @(negedge aclk);
    set_port(1, 1'b1, 1'b1, 32'h8000_0010);
    #1;
    checks++; if (addr_ok !== 2'b10) begin errors++; $display("FAIL raw_wr_addr_ok got=%b exp=10", addr_ok); end
    @(negedge aclk);
    set_port(1, 1'b0, 1'b0, 32'h0);
    set_port(0, 1'b1, 1'b0, 32'h8000_0012);
    #1;
    checks++; if ({awvalid, awaddr, awsize, wvalid, axi_wdata, axi_wstrb} !== {1'b1, 32'h8000_0010, 3'd2, 1'b1, 32'hDA5A_5A4A, 4'hF}) begin errors++; $display("FAIL raw_aw_w got=%h", {awvalid, awaddr, awsize, wvalid, axi_wdata, axi_wstrb}); end
    checks++; if (addr_ok !== 2'b00) begin errors++; $display("FAIL raw_block_aw got=%b exp=00", addr_ok); end
    @(negedge aclk);
    #1;
    checks++; if (addr_ok !== 2'b00) begin errors++; $display("FAIL raw_block_fifo got=%b exp=00", addr_ok); end
    set_port(0, 1'b1, 1'b0, 32'h8000_0020);
    #1;
    checks++; if (addr_ok !== 2'b01) begin errors++; $display("FAIL raw_other_addr got=%b exp=01", addr_ok); end
    @(negedge aclk);
    set_port(0, 1'b1, 1'b0, 32'h8000_0012);
    #1;
    checks++; if ({arvalid, araddr} !== {1'b1, 32'h8000_0020}) begin errors++; $display("FAIL raw_ar got=%h exp=%h", {arvalid, araddr}, {1'b1, 32'h8000_0020}); end
    checks++; if (addr_ok !== 2'b00) begin errors++; $display("FAIL raw_still_blocked got=%b exp=00", addr_ok); end
    @(negedge aclk);
    bvalid = 1'b1;
    #1;
    checks++; if ({data_ok, addr_ok} !== 4'b1000) begin errors++; $display("FAIL raw_b got=%b exp=1000", {data_ok, addr_ok}); end
    @(negedge aclk);
    bvalid = 1'b0;
    #1;
    checks++; if (addr_ok !== 2'b01) begin errors++; $display("FAIL raw_released got=%b exp=01", addr_ok); end
    @(negedge aclk);
    set_port(0, 1'b0, 1'b0, 32'h0);
    #1;
    checks++; if (araddr !== 32'h8000_0012) begin errors++; $display("FAIL raw_ar2 got=%h exp=80000012", araddr); end
    for (int n = 0; n < 2; n++) begin
      @(negedge aclk);
      rvalid = 1'b1; rid = 4'd0;
      #1;
      checks++; if (data_ok !== 2'b01) begin errors++; $display("FAIL raw_drain%0d got=%b exp=01", n, data_ok); end
    end
    @(negedge aclk);
    rvalid = 1'b0;
  endtask

  task automatic test_write_fifo();
    int          wport [5] = '{0, 1, 1, 0, 0};
    logic [1:0]  exp_ok [6] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00};
    logic [1:0]  exp_b [5] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge aclk);
      set_port(0, 1'b0, 1'b0, 32'h0);
      set_port(1, 1'b0, 1'b0, 32'h0);
      set_port(wport[(k < 5) ? k : 4], 1'b1, 1'b1, 32'h9000_0000 + 32'(16*k));
      #1;
      checks++; if (addr_ok !== exp_ok[k]) begin errors++; $display("FAIL wr_accept%0d got=%b exp=%b", k, addr_ok, exp_ok[k]); end
    end
    @(negedge aclk);
    bvalid = 1'b1;
    #1;
    checks++; if ({data_ok, addr_ok} !== 4'b0100) begin errors++; $display("FAIL wr_full_pop got=%b exp=0100", {data_ok, addr_ok}); end
    @(negedge aclk);
    bvalid = 1'b0;
    #1;
    checks++; if (addr_ok !== 2'b01) begin errors++; $display("FAIL wr_fifth got=%b exp=01", addr_ok); end
    @(negedge aclk);
    set_port(0, 1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 5; n++) begin
      bvalid = 1'b1;
      #1;
      checks++; if (data_ok !== exp_b[n]) begin errors++; $display("FAIL wr_b%0d got=%b exp=%b", n, data_ok, exp_b[n]); end
      @(negedge aclk);
    end
    bvalid = 1'b0;
  endtask

  task automatic test_reset_inflight();
    arready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      set_port(0, 1'b1, 1'b0, 32'hA000_0000 + 32'(4*k));
      #1;
      checks++; if (addr_ok !== 2'b01) begin errors++; $display("FAIL rst_pre%0d got=%b exp=01", k, addr_ok); end
    end
    @(negedge aclk);
    set_port(0, 1'b0, 1'b0, 32'h0);
    aresetn = 1'b0;
    #1;
    checks++; if ({arvalid, awvalid, wvalid, addr_ok, data_ok} !== 7'b0) begin errors++; $display("FAIL rst_async got=%b exp=0000000", {arvalid, awvalid, wvalid, addr_ok, data_ok}); end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    rvalid = 1'b1; rid = 4'd0; axi_rdata = 32'hBAD0_BAD0; bvalid = 1'b1;
    #1;
    checks++; if ({data_ok, rdata} !== 66'b0) begin errors++; $display("FAIL rst_stale got=%h exp=0", {data_ok, rdata}); end
    checks++; if ({arvalid, awvalid, wvalid, addr_ok} !== 5'b0) begin errors++; $display("FAIL rst_outputs got=%b exp=00000", {arvalid, awvalid, wvalid, addr_ok}); end
    @(negedge aclk);
    rvalid = 1'b0; bvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arb();
    test_single_read();
    test_max_outstanding();
    test_raw();
    test_write_fifo();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
